// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a SYNC_W-bit sync pattern in a serial stream, then deserialises DATA_W bits MSB-first.
// Latency: VALID rises right after the edge that samples the last payload bit (DATA_W edges after the sync match).
// Backpressure: a word held in DATA_OUT waits for READY; a word completing while the previous one is untaken is dropped and OVERRUN pulses.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RST      asynchronous active-high reset
//   D_IN     serial bit, sampled every rising edge
//   DATA_OUT received payload word, MSB = first payload bit received
//   VALID    DATA_OUT holds an untaken word
//   READY    consumer accepts the word when VALID && READY at a rising edge
//   BUSY     high while a payload is being received
//   OVERRUN  one-cycle pulse when a completed word is dropped
module serial_frame_rx #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              D_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              OVERRUN
);

  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]        state;
  logic [SYNC_W-1:0] window;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;

  logic [SYNC_W-1:0] win_next;
  logic [FILL_W-1:0] fill_next;
  logic [DATA_W-1:0] shift_next;
  logic              sync_hit;
  logic              word_done;

  always_comb begin
    // Truncating casts keep the newest bits; this also covers 1-bit widths.
    win_next   = SYNC_W'({window, D_IN});
    shift_next = DATA_W'({shreg, D_IN});
    fill_next  = (fill == FILL_W'(SYNC_W)) ? fill : fill + FILL_W'(1);
    // Match is evaluated on the window including the bit sampled this edge,
    // and only once SYNC_W bits have been collected since the last clear.
    sync_hit   = (state == HUNT) && (fill_next == FILL_W'(SYNC_W)) &&
                 (win_next == SYNC_PATTERN);
    word_done  = (state == RECV) && (bit_cnt == CNT_W'(DATA_W - 1));
  end

  assign BUSY = (state == RECV);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= HUNT;
      window   <= '0;
      fill     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      DATA_OUT <= '0;
      VALID    <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      OVERRUN <= 1'b0;

      if (state == HUNT) begin
        window <= win_next;
        fill   <= fill_next;
        if (sync_hit) begin
          state   <= RECV;
          bit_cnt <= '0;
        end
      end else begin
        shreg   <= shift_next;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (word_done) begin
          // Start the next hunt from an empty window so payload bits can
          // never complete a sync pattern.
          state   <= HUNT;
          window  <= '0;
          fill    <= '0;
          bit_cnt <= '0;
        end
      end

      if (word_done) begin
        if (!VALID || READY) begin
          DATA_OUT <= shift_next;
          VALID    <= 1'b1;
        end else begin
          OVERRUN  <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed bench for serial_frame_rx (DATA_W=8, SYNC_W=4, pattern 1011).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Expected values are hand-computed per test step.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       d_in;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int busy_seen;
  int valid_seen;

  serial_frame_rx #(
    .DATA_W      (8),
    .SYNC_W      (4),
    .SYNC_PATTERN(4'b1011)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .D_IN    (d_in),
    .DATA_OUT(data_out),
    .VALID   (valid),
    .READY   (ready),
    .BUSY    (busy),
    .OVERRUN (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one bit, let one rising edge sample it, settle 1 unit past the edge.
  task automatic send_bit(input logic b);
    d_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send the low n bits of v, MSB first.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    rst   = 1'b1;
    d_in  = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_data",    32'(data_out), 32'h00);
    check_eq("rst_valid",   32'(valid),    0);
    check_eq("rst_busy",    32'(busy),     0);
    check_eq("rst_overrun", 32'(overrun),  0);
    rst = 1'b0;

    // Test 1: sync 1011 + A5 with READY=0, then accept.
    send_bits(16'b101, 3);
    check_eq("t1_busy_pre", 32'(busy), 0);
    send_bit(1'b1);
    check_eq("t1_busy_match", 32'(busy), 1);
    send_bits(16'hA5 >> 1, 7);
    check_eq("t1_valid_early", 32'(valid), 0);
    check_eq("t1_busy_mid",    32'(busy),  1);
    send_bit(1'b1);
    check_eq("t1_data",  32'(data_out), 32'hA5);
    check_eq("t1_valid", 32'(valid),    1);
    check_eq("t1_busy",  32'(busy),     0);
    send_bits(16'b000, 3);
    check_eq("t1_valid_held", 32'(valid), 1);
    ready = 1'b1;
    send_bit(1'b0);
    check_eq("t1_valid_clr", 32'(valid), 0);
    check_eq("t1_data_hold", 32'(data_out), 32'hA5);

    // Test 2: noise with overlapping candidate, READY=1.
    send_bits(16'b001101, 6);
    check_eq("t2_busy_pre", 32'(busy), 0);
    send_bit(1'b1);
    check_eq("t2_busy_match", 32'(busy), 1);
    send_bits(16'h3C, 8);
    check_eq("t2_data",  32'(data_out), 32'h3C);
    check_eq("t2_valid", 32'(valid),    1);
    send_bit(1'b0);
    check_eq("t2_valid_pulse", 32'(valid), 0);

    // Test 3: back-to-back frames, READY=0 -> second word dropped.
    ready = 1'b0;
    send_bits(16'b1011, 4);
    send_bits(16'h12, 8);
    check_eq("t3_data1",  32'(data_out), 32'h12);
    check_eq("t3_valid1", 32'(valid),    1);
    send_bits(16'b1011, 4);
    send_bits(16'hFE >> 1, 7);
    check_eq("t3_ovr_pre", 32'(overrun), 0);
    send_bit(1'b0);
    check_eq("t3_overrun", 32'(overrun),  1);
    check_eq("t3_data2",   32'(data_out), 32'h12);
    check_eq("t3_valid2",  32'(valid),    1);
    send_bit(1'b0);
    check_eq("t3_ovr_pulse", 32'(overrun), 0);
    ready = 1'b1;
    send_bit(1'b0);
    check_eq("t3_valid_clr", 32'(valid), 0);

    // Test 4: same frames, READY=1 only at the second completion edge.
    ready = 1'b0;
    send_bits(16'b1011, 4);
    send_bits(16'h12, 8);
    send_bits(16'b1011, 4);
    send_bits(16'hFE >> 1, 7);
    check_eq("t4_valid_pre", 32'(valid),    1);
    check_eq("t4_data_pre",  32'(data_out), 32'h12);
    ready = 1'b1;
    send_bit(1'b0);
    check_eq("t4_data",    32'(data_out), 32'hFE);
    check_eq("t4_valid",   32'(valid),    1);
    check_eq("t4_overrun", 32'(overrun),  0);
    send_bit(1'b0);
    check_eq("t4_valid_clr", 32'(valid), 0);

    // Test 5: payload containing the sync pattern, then zeros.
    send_bits(16'b1011, 4);
    send_bits(16'hBB, 8);
    check_eq("t5_data",  32'(data_out), 32'hBB);
    check_eq("t5_valid", 32'(valid),    1);
    busy_seen  = 0;
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b0);
      if (busy)  busy_seen++;
      if (valid) valid_seen++;
    end
    check_eq("t5_no_busy",  32'(busy_seen),  0);
    check_eq("t5_no_valid", 32'(valid_seen), 0);

    // Test 6: async reset mid-frame, then a clean frame.
    ready = 1'b0;
    send_bits(16'b1011, 4);
    send_bits(16'b110, 3);
    check_eq("t6_busy_pre", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy",    32'(busy),     0);
    check_eq("t6_rst_valid",   32'(valid),    0);
    check_eq("t6_rst_data",    32'(data_out), 32'h00);
    check_eq("t6_rst_overrun", 32'(overrun),  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_bits(16'b1011, 4);
    check_eq("t6_busy_match", 32'(busy), 1);
    send_bits(16'h5A >> 1, 7);
    check_eq("t6_valid_early", 32'(valid), 0);
    send_bit(1'b0);
    check_eq("t6_data",  32'(data_out), 32'h5A);
    check_eq("t6_valid", 32'(valid),    1);
    check_eq("t6_busy",  32'(busy),     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
